peripheral_intc_ahb3: RTL
=========================

Name: peripheral_intc_ahb3

Overview:
- AHB3-Lite slave interrupt controller that sits directly downstream of the AHB3 timer and other MPSoC peripherals.
- Collects their interrupt lines (e.g. the timer's `tint`) through per-source gateways.
- Arbitrates by programmable priority and drives a single `irq` to the core.
- The core acknowledges through a claim/complete register pair.

Parameters:
- HADDR_SIZE, 32, AHB address width
- HDATA_SIZE, 32, AHB data width; only 32 supported
- SOURCES, 8, number of interrupt sources (1..31)
- PRIO_BITS, 3, priority field width per source

Ports:
- HRESETn  in  1  asynchronous active-low reset
- HCLK  in  1  single clock; all logic on rising edge
- HSEL  in  1  slave select
- HADDR  in  HADDR_SIZE  address
- HWDATA  in  HDATA_SIZE  write data
- HRDATA  out  HDATA_SIZE  read data, registered
- HWRITE  in  1  write transfer
- HSIZE  in  3  transfer size
- HBURST  in  3  burst type (ignored)
- HPROT  in  4  protection (ignored)
- HTRANS  in  2  transfer type
- HREADYOUT  out  1  tied 1, zero wait states
- HREADY  in  1  bus ready
- HRESP  out  1  tied OKAY
- src  in  SOURCES  interrupt requests, active-high (bit n = source ID n+1)
- irq  out  1  interrupt to core, registered

Behaviour:
- **Reset:** all registers, gateways, HRDATA and irq are 0.
- **Transfer acceptance:** a transfer is valid when HREADY & HSEL & HTRANS is NONSEQ or SEQ.
  - Write address, byte-enables (from HSIZE/HADDR[1:0]) and a write flag are captured on that edge.
  - The write is applied on the next edge using HWDATA with byte-lane merging.
- **Reads:** HRDATA is registered on the address-phase edge and is valid in the data phase.
- **Register map (word addresses):**
  - 0x00 ENABLE: RW, [SOURCES-1:0].
  - 0x04 PENDING: RO.
  - 0x08 EDGE: RW; 1 = edge, 0 = level.
  - 0x0C THRESHOLD: RW, [PRIO_BITS-1:0].
  - 0x10 CLAIM: read = claim; write = complete.
  - 0x20+4n PRIORITY[n]: RW, [PRIO_BITS-1:0].
  - Unmapped addresses read 0 and ignore writes.
  - Unused upper bits read 0.
- **Gateway FSM (per source):** states IDLE, PEND, CLAIMED.
  - IDLE -> PEND:
    - level mode: when src=1;
    - edge mode: on a src 0->1 transition, detected against a registered src_d.
  - PEND -> CLAIMED on a claim that selects this source.
  - CLAIMED -> IDLE on a complete write whose HWDATA[4:0] equals this ID.
  - Edges arriving in PEND or CLAIMED are dropped; there is no counting.
  - In level mode, re-entry to PEND happens the cycle after IDLE if src is still high.
  - PENDING[n] = (state==PEND).
  - Changing EDGE[n] does not alter the current state.
- **Arbitration (combinational each cycle):**
  - Candidates are sources that are pending, have ENABLE=1 and PRIORITY>0.
  - Pick the maximum priority; ties go to the lowest ID.
  - best_id = 0 if there is no candidate.
- **irq:** registered; `irq <= (best_id!=0) && (best_prio > THRESHOLD)`.
  - THRESHOLD = max value masks everything.
- **Claim:** an accepted read of 0x10 captures HRDATA = best_id (0 if none or if irq is masked by THRESHOLD).
  - On the same edge, the selected gateway moves PEND->CLAIMED.
  - Back-to-back claims return distinct IDs.
- **Complete:**
  - An ID of 0 or greater than SOURCES is ignored.
  - A complete to a source not in CLAIMED is ignored.
- **Simultaneous events:**
  - Claim and a new edge on a different source: both take effect.
  - Complete and src-high in level mode: IDLE this cycle, PEND next.
- **Reset mid-operation** returns every gateway to IDLE and drops irq asynchronously.

Optional Feature:
- Macro: PERIPHERAL_INTC_SYNC_EN.
- **Defined:** src passes through a 2-flop synchronizer (reset 0) before the gateways. Edge/level detection is delayed by 2 cycles, and asynchronous sources are allowed.
- **Undefined:** src is used directly. Sources must be synchronous to HCLK (e.g. `tint`).

Decomposition:
- **Existing peripheral_ahb3_pkg:** HTRANS_*, HSIZE_* and HRESP_OKAY come from here.
- **New peripheral_intc_pkg:**
  - register offset localparams (INTC_ENABLE, INTC_PENDING, INTC_EDGE, INTC_THRESHOLD, INTC_CLAIM, INTC_PRIORITY);
  - gateway state enum typedef gw_state_t {GW_IDLE, GW_PEND, GW_CLAIMED}.
- **Sub-module peripheral_intc_gateway:** one instance per source.
  - Inputs: clk/reset, src, edge_mode, claim, complete.
  - Output: pending.

Test Plan:
- Reset, then read all registers -> every read returns 0; irq=0, HREADYOUT=1, HRESP=OKAY.
- Source 1 level mode, ENABLE=0x1, PRIORITY[0]=3, THRESHOLD=0, src[0]=1 -> PENDING=0x1, irq=1 one cycle after pending.
  - Claim read returns 1; PENDING=0 and irq=0.
  - Complete write 1 while src high -> PENDING=0x1 again.
- Sources 2 and 5 pending with priority 2 and 2, source 3 with priority 1 -> claims return 2, then 5, then 3, then 0.
- Edge mode source 4, pulse src[3] three times while CLAIMED -> after complete 4, PENDING=0 (pulses dropped); a new pulse re-pends.
- THRESHOLD=3 with the only pending priority 3 -> irq=0 and a claim returns 0; set THRESHOLD=2 -> irq=1.
- With PERIPHERAL_INTC_SYNC_EN: src rising -> PENDING set 2 cycles later than without the macro. Assert HRESETn mid-CLAIMED -> irq falls immediately and all state reads 0.

Source files
------------

// File: rtl/peripheral_ahb3_pkg.sv
// Shared AHB3-Lite encodings used by the peripheral slaves.
package peripheral_ahb3_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HSIZE_BYTE  = 3'b000;
    localparam logic [2:0] HSIZE_HWORD = 3'b001;
    localparam logic [2:0] HSIZE_WORD  = 3'b010;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

endpackage

// File: rtl/peripheral_intc_pkg.sv
// Interrupt controller register offsets, gateway states and byte-lane helper.
package peripheral_intc_pkg;
    import peripheral_ahb3_pkg::*;

    localparam logic [7:0] INTC_ENABLE    = 8'h00;
    localparam logic [7:0] INTC_PENDING   = 8'h04;
    localparam logic [7:0] INTC_EDGE      = 8'h08;
    localparam logic [7:0] INTC_THRESHOLD = 8'h0C;
    localparam logic [7:0] INTC_CLAIM     = 8'h10;
    localparam logic [7:0] INTC_PRIORITY  = 8'h20;

    typedef enum logic [1:0] {
        GW_IDLE    = 2'd0,
        GW_PEND    = 2'd1,
        GW_CLAIMED = 2'd2
    } gw_state_t;

    function automatic logic [3:0] intc_byte_en(input logic [2:0] hsize, input logic [1:0] addr);
        case (hsize)
            HSIZE_BYTE:  return 4'b0001 << addr;
            HSIZE_HWORD: return addr[1] ? 4'b1100 : 4'b0011;
            default:     return 4'b1111;
        endcase
    endfunction

endpackage

// File: rtl/peripheral_intc_gateway.sv
// Per-source gateway: qualifies level/edge requests and tracks the claim/complete handshake.
// state      | meaning
// GW_IDLE    | no request outstanding, watching src
// GW_PEND    | request latched, eligible for arbitration
// GW_CLAIMED | claimed by the core, waiting for complete
module peripheral_intc_gateway
    import peripheral_intc_pkg::*;
(
    input  logic HCLK,
    input  logic HRESETn,
    input  logic src,
    input  logic edge_mode,
    input  logic claim,
    input  logic complete,
    output logic pending
);

    gw_state_t state_q;
    logic      src_d;
    logic      trigger;

    // Edges seen outside IDLE are simply lost: there is no request counter.
    assign trigger = edge_mode ? (src & ~src_d) : src;

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q <= GW_IDLE;
            src_d   <= 1'b0;
        end else begin
            src_d <= src;
            case (state_q)
                GW_IDLE:    if (trigger)  state_q <= GW_PEND;
                GW_PEND:    if (claim)    state_q <= GW_CLAIMED;
                GW_CLAIMED: if (complete) state_q <= GW_IDLE;
                default:                  state_q <= GW_IDLE;
            endcase
        end
    end

    assign pending = (state_q == GW_PEND);

endmodule

// File: rtl/peripheral_intc_ahb3.sv
// AHB3-Lite interrupt controller: per-source gateways, priority arbitration, claim/complete.
// Optional PERIPHERAL_INTC_SYNC_EN adds a 2-flop synchronizer on src for asynchronous sources.
module peripheral_intc_ahb3
    import peripheral_ahb3_pkg::*;
    import peripheral_intc_pkg::*;
#(
    parameter int HADDR_SIZE = 32,
    parameter int HDATA_SIZE = 32,
    parameter int SOURCES    = 8,
    parameter int PRIO_BITS  = 3
) (
    input  logic                  HRESETn,
    input  logic                  HCLK,
    input  logic                  HSEL,
    input  logic [HADDR_SIZE-1:0] HADDR,
    input  logic [HDATA_SIZE-1:0] HWDATA,
    output logic [HDATA_SIZE-1:0] HRDATA,
    input  logic                  HWRITE,
    input  logic [2:0]            HSIZE,
    input  logic [2:0]            HBURST,
    input  logic [3:0]            HPROT,
    input  logic [1:0]            HTRANS,
    output logic                  HREADYOUT,
    input  logic                  HREADY,
    output logic                  HRESP,
    input  logic [SOURCES-1:0]    src,
    output logic                  irq
);

    logic                 accept;
    logic [7:0]           wr_addr_q;
    logic [3:0]           wr_be_q;
    logic                 wr_en_q;
    logic [5:0]           wr_word;
    logic [5:0]           rd_word;
    logic [HDATA_SIZE-1:0] wr_mask;
    logic [HDATA_SIZE-1:0] wr_old;
    logic [HDATA_SIZE-1:0] wr_merged;
    logic [HDATA_SIZE-1:0] rd_data;

    logic [SOURCES-1:0]   enable_q;
    logic [SOURCES-1:0]   edge_q;
    logic [PRIO_BITS-1:0] threshold_q;
    logic [PRIO_BITS-1:0] prio_q [SOURCES];

    logic [SOURCES-1:0]   src_gw;
    logic [SOURCES-1:0]   pending;
    logic [SOURCES-1:0]   claim;
    logic [SOURCES-1:0]   complete;
    logic [4:0]           best_id;
    logic [PRIO_BITS-1:0] best_prio;
    logic                 irq_next;
    logic [4:0]           claim_id;
    logic                 unused_ok;

    assign HREADYOUT = 1'b1;
    assign HRESP     = HRESP_OKAY;

    assign accept  = HREADY & HSEL & ((HTRANS == HTRANS_NONSEQ) | (HTRANS == HTRANS_SEQ));
    // The block occupies 256 bytes; HSEL already decodes the base address.
    assign rd_word = HADDR[7:2];
    assign wr_word = wr_addr_q[7:2];

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_be_q   <= '0;
        end else begin
            wr_en_q <= accept & HWRITE;
            if (accept & HWRITE) begin
                wr_addr_q <= HADDR[7:0];
                wr_be_q   <= intc_byte_en(HSIZE, HADDR[1:0]);
            end
        end
    end

`ifdef PERIPHERAL_INTC_SYNC_EN
    logic [SOURCES-1:0] src_s1;
    logic [SOURCES-1:0] src_s2;

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            src_s1 <= '0;
            src_s2 <= '0;
        end else begin
            src_s1 <= src;
            src_s2 <= src_s1;
        end
    end

    assign src_gw = src_s2;
`else
    assign src_gw = src;
`endif

    for (genvar g = 0; g < SOURCES; g++) begin : g_gw
        peripheral_intc_gateway u_gw (
            .HCLK      (HCLK),
            .HRESETn   (HRESETn),
            .src       (src_gw[g]),
            .edge_mode (edge_q[g]),
            .claim     (claim[g]),
            .complete  (complete[g]),
            .pending   (pending[g])
        );
    end

    // Strict '>' while scanning upward keeps the lowest ID on priority ties.
    always_comb begin
        best_id   = '0;
        best_prio = '0;
        for (int i = 0; i < SOURCES; i++) begin
            if (pending[i] && enable_q[i] && (prio_q[i] > best_prio)) begin
                best_prio = prio_q[i];
                best_id   = 5'(i + 1);
            end
        end
    end

    assign irq_next = (best_id != 5'd0) && (best_prio > threshold_q);
    assign claim_id = irq_next ? best_id : 5'd0;

    always_comb begin
        claim = '0;
        if (accept && !HWRITE && (rd_word == INTC_CLAIM[7:2])) begin
            for (int i = 0; i < SOURCES; i++)
                if (claim_id == 5'(i + 1)) claim[i] = 1'b1;
        end
    end

    always_comb begin
        complete = '0;
        if (wr_en_q && wr_be_q[0] && (wr_word == INTC_CLAIM[7:2])) begin
            for (int i = 0; i < SOURCES; i++)
                if (HWDATA[4:0] == 5'(i + 1)) complete[i] = 1'b1;
        end
    end

    always_comb begin
        rd_data = '0;
        if (rd_word == INTC_ENABLE[7:2])         rd_data[SOURCES-1:0]   = enable_q;
        else if (rd_word == INTC_PENDING[7:2])   rd_data[SOURCES-1:0]   = pending;
        else if (rd_word == INTC_EDGE[7:2])      rd_data[SOURCES-1:0]   = edge_q;
        else if (rd_word == INTC_THRESHOLD[7:2]) rd_data[PRIO_BITS-1:0] = threshold_q;
        else if (rd_word == INTC_CLAIM[7:2])     rd_data[4:0]           = claim_id;
        for (int i = 0; i < SOURCES; i++)
            if (rd_word == 6'(INTC_PRIORITY[7:2] + 6'(i))) rd_data[PRIO_BITS-1:0] = prio_q[i];
    end

    always_comb begin
        wr_old = '0;
        if (wr_word == INTC_ENABLE[7:2])         wr_old[SOURCES-1:0]   = enable_q;
        else if (wr_word == INTC_EDGE[7:2])      wr_old[SOURCES-1:0]   = edge_q;
        else if (wr_word == INTC_THRESHOLD[7:2]) wr_old[PRIO_BITS-1:0] = threshold_q;
        for (int i = 0; i < SOURCES; i++)
            if (wr_word == 6'(INTC_PRIORITY[7:2] + 6'(i))) wr_old[PRIO_BITS-1:0] = prio_q[i];
    end

    assign wr_mask   = {{8{wr_be_q[3]}}, {8{wr_be_q[2]}}, {8{wr_be_q[1]}}, {8{wr_be_q[0]}}};
    assign wr_merged = (wr_old & ~wr_mask) | (HWDATA & wr_mask);

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            enable_q    <= '0;
            edge_q      <= '0;
            threshold_q <= '0;
            for (int i = 0; i < SOURCES; i++) prio_q[i] <= '0;
        end else if (wr_en_q) begin
            if (wr_word == INTC_ENABLE[7:2])         enable_q    <= wr_merged[SOURCES-1:0];
            else if (wr_word == INTC_EDGE[7:2])      edge_q      <= wr_merged[SOURCES-1:0];
            else if (wr_word == INTC_THRESHOLD[7:2]) threshold_q <= wr_merged[PRIO_BITS-1:0];
            for (int i = 0; i < SOURCES; i++)
                if (wr_word == 6'(INTC_PRIORITY[7:2] + 6'(i))) prio_q[i] <= wr_merged[PRIO_BITS-1:0];
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            HRDATA <= '0;
            irq    <= 1'b0;
        end else begin
            irq <= irq_next;
            if (accept && !HWRITE) HRDATA <= rd_data;
        end
    end

    assign unused_ok = ^{HBURST, HPROT, HADDR, wr_merged};

endmodule
